// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC and issues one outstanding request at a
// time on the SRAM-like instruction port. Returned instructions are queued in a
// small FIFO whose head feeds the ID pipeline register. Redirects flush the FIFO;
// a response still in flight for a cancelled request is swallowed in S_DROP.
// Optional build macro IF_FETCH_PERF_EN adds drop and bubble counters.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_Wr,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        IF_Valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_AdEL
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_nxt;
  logic [31:0]     r_req_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;

  logic [31:0]     r_buf_pc    [BUF_DEPTH];
  logic [31:0]     r_buf_instr [BUF_DEPTH];
  logic            r_buf_adel  [BUF_DEPTH];

  logic            w_redir;
  logic [31:0]     w_target;
  logic            w_has_free;
  logic            w_aligned;
  logic            w_req;
  logic            w_accept;
  logic            w_outstanding;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_push_pc;
  logic [31:0]     w_push_instr;
  logic            w_push_adel;

  assign w_redir    = exc_valid | redirect_valid;
  assign w_target   = exc_valid ? exc_pc : redirect_pc;
  assign w_has_free = (r_count < DEPTH_C);
  assign w_aligned  = (r_pc[1:0] == 2'b00);
  // Gated by resetn so nothing is requested while reset is held.
  assign w_req      = resetn && (r_state == S_REQ) && w_aligned && w_has_free;
  assign w_accept   = w_req && inst_addr_ok;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && ID_Wr;

  // A response is still owed to us after this edge.
  assign w_outstanding = (((r_state == S_WAIT) || (r_state == S_DROP)) && !inst_data_ok) || w_accept;

  assign inst_req  = w_req;
  // Address mirrors the PC; forced to zero while reset is asserted.
  assign inst_addr = resetn ? r_pc : 32'h0;

  // Head entry masked when empty so stale buffer contents never leak out.
  assign IF_Valid = w_valid;
  assign IF_PC    = w_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;
  assign IF_Instr = w_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
  assign IF_AdEL  = w_valid ? r_buf_adel[r_rd_ptr]  : 1'b0;

  // Next-state, next-PC and push decision; a redirect overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_push       = 1'b0;
    w_push_pc    = r_req_pc;
    w_push_instr = inst_rdata;
    w_push_adel  = 1'b0;
    case (r_state)
      S_REQ: begin
        if (w_aligned) begin
          if (w_accept) begin
            w_state_nxt = S_WAIT;
            w_pc_nxt    = r_pc + 32'd4;
          end
        end else if (w_has_free) begin
          w_push       = 1'b1;
          w_push_pc    = r_pc;
          w_push_instr = 32'h0;
          w_push_adel  = 1'b1;
          w_state_nxt  = S_HALT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          w_push      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (inst_data_ok) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
    if (w_redir) begin
      w_push      = 1'b0;
      w_pc_nxt    = w_target;
      w_state_nxt = w_outstanding ? S_DROP : S_REQ;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Remember the address of the request in flight for tagging its response.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req_pc <= r_pc;
    end
  end

  // FIFO occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (w_redir) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= w_push_pc;
      r_buf_instr[r_wr_ptr] <= w_push_instr;
      r_buf_adel[r_wr_ptr]  <= w_push_adel;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic w_drop;
  assign w_drop = inst_data_ok && ((r_state == S_DROP) || (w_redir && (r_state == S_WAIT)));

  // Count discarded responses and cycles where ID wanted an instruction but none was ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_drop_cnt   <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else begin
      if (w_drop) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
      if (!w_valid && ID_Wr) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a small instruction-memory model
// (configurable response latency, instruction word = ~address).
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ID_Wr;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        IF_AdEL;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        mem_ack;
  int          lat;
  logic        pend;
  logic [31:0] paddr;
  int          pcnt;
  logic [31:0] pc_e;

  if_fetch_ctrl #(
    .RESET_PC  (32'hBFC0_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ID_Wr          (ID_Wr),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_rdata     (inst_rdata),
    .inst_data_ok   (inst_data_ok),
`ifdef IF_FETCH_PERF_EN
    .perf_drop_cnt   (perf_drop_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
`endif
    .IF_Valid       (IF_Valid),
    .IF_PC          (IF_PC),
    .IF_Instr       (IF_Instr),
    .IF_AdEL        (IF_AdEL)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: memory model samples the handshake, then outputs settle 1 time unit after the edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    inst_addr_ok = mem_ack;
    acc = inst_req && inst_addr_ok;
    a   = inst_addr;
    @(posedge clk);
    #1;
    if (inst_data_ok) pend = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      paddr = a;
      pcnt  = lat - 1;
    end else if (pend && pcnt > 0) begin
      pcnt--;
    end
    inst_data_ok = pend && (pcnt == 0);
    inst_rdata   = inst_data_ok ? ~paddr : 32'h0;
  endtask

  initial begin
    resetn = 1'b0; ID_Wr = 1'b1; exc_valid = 1'b0; exc_pc = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    mem_ack = 1'b1; lat = 1; pend = 1'b0; paddr = 32'h0; pcnt = 0; pc_e = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req",   inst_req, 32'd0);
    chk("rst_valid", IF_Valid, 32'd0);
    chk("rst_pc",    IF_PC,    32'd0);
    chk("rst_instr", IF_Instr, 32'd0);
    chk("rst_adel",  IF_AdEL,  32'd0);
    resetn = 1'b1; #1;
    chk("rel_req", inst_req, 32'd1);

    // Sequential fetch, 1-cycle memory, ID always accepting
    for (int i = 0; i < 4; i++) begin
      pc_e = 32'hBFC0_0000 + 32'(4 * i);
      chk("seq_addr", inst_addr, pc_e);
      chk("seq_req",  inst_req,  32'd1);
      tick();
      chk("seq_wait_req", inst_req, 32'd0);
      chk("seq_gap",      IF_Valid, 32'd0);
      tick();
      chk("seq_valid", IF_Valid, 32'd1);
      chk("seq_pc",    IF_PC,    pc_e);
      chk("seq_instr", IF_Instr, ~pc_e);
    end

    // Reset asserted while a request is in flight
    tick();
    chk("mid_wait_req", inst_req, 32'd0);
    resetn = 1'b0; #1;
    chk("arst_req",   inst_req,  32'd0);
    chk("arst_addr",  inst_addr, 32'd0);
    chk("arst_valid", IF_Valid,  32'd0);
    chk("arst_pc",    IF_PC,     32'd0);
    chk("arst_instr", IF_Instr,  32'd0);
    chk("arst_adel",  IF_AdEL,   32'd0);
    ID_Wr = 1'b0;
    tick(); tick();
    chk("arst_stale_valid", IF_Valid, 32'd0);
    chk("arst_stale_req",   inst_req, 32'd0);
    resetn = 1'b1; #1;
    chk("rel2_req",  inst_req,  32'd1);
    chk("rel2_addr", inst_addr, 32'hBFC0_0000);

    // Backpressure: FIFO fills to two entries, then requests stop
    tick(); tick();
    chk("bp1_valid", IF_Valid,  32'd1);
    chk("bp1_pc",    IF_PC,     32'hBFC0_0000);
    chk("bp1_req",   inst_req,  32'd1);
    chk("bp1_addr",  inst_addr, 32'hBFC0_0004);
    tick(); tick();
    chk("bp_full_req", inst_req, 32'd0);
    chk("bp_full_pc",  IF_PC,    32'hBFC0_0000);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("bp_hold_req",  inst_req,  32'd0);
      chk("bp_hold_pc",   IF_PC,     32'hBFC0_0000);
      chk("bp_hold_addr", inst_addr, 32'hBFC0_0008);
    end
    ID_Wr = 1'b1;
    tick();
    chk("drain_valid", IF_Valid,  32'd1);
    chk("drain_pc",    IF_PC,     32'hBFC0_0004);
    chk("drain_instr", IF_Instr,  ~32'hBFC0_0004);
    chk("drain_req",   inst_req,  32'd1);
    chk("drain_addr",  inst_addr, 32'hBFC0_0008);
    tick();
    chk("drain_empty", IF_Valid, 32'd0);
    chk("drain_wait",  inst_req, 32'd0);

    // Redirect in S_WAIT: response for 0xBFC00008 lands in the redirect cycle and is dropped
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid", IF_Valid,  32'd0);
    chk("rd_req",   inst_req,  32'd1);
    chk("rd_addr",  inst_addr, 32'h8000_1000);
    tick();
    chk("rd_gap", IF_Valid, 32'd0);
    tick();
    chk("rd_hit_valid", IF_Valid,  32'd1);
    chk("rd_hit_pc",    IF_PC,     32'h8000_1000);
    chk("rd_hit_instr", IF_Instr,  32'h7FFF_EFFF);
    chk("rd_next_addr", inst_addr, 32'h8000_1004);

    // Exception and branch together while a slow response is pending: drop then fetch exc_pc
    lat = 3;
    tick();
    chk("ex_pre_valid", IF_Valid, 32'd0);
    chk("ex_pre_req",   inst_req, 32'd0);
    exc_valid = 1'b1; exc_pc = 32'hBFC0_0380;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    tick();
    exc_valid = 1'b0; redirect_valid = 1'b0;
    chk("ex_drop_req",   inst_req,  32'd0);
    chk("ex_drop_addr",  inst_addr, 32'hBFC0_0380);
    chk("ex_drop_valid", IF_Valid,  32'd0);
    tick();
    chk("ex_drop_req2", inst_req, 32'd0);
    tick();
    chk("ex_req",   inst_req,  32'd1);
    chk("ex_addr",  inst_addr, 32'hBFC0_0380);
    chk("ex_valid", IF_Valid,  32'd0);
    lat = 1;
    tick(); tick();
    chk("ex_hit_valid", IF_Valid,  32'd1);
    chk("ex_hit_pc",    IF_PC,     32'hBFC0_0380);
    chk("ex_hit_instr", IF_Instr,  32'h403F_FC7F);
    chk("ex_next_addr", inst_addr, 32'hBFC0_0384);

    // Misaligned redirect: address-error entry, then halt until redirected
    mem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    tick();
    redirect_valid = 1'b0; ID_Wr = 1'b0; mem_ack = 1'b1;
    chk("ade_req",   inst_req, 32'd0);
    chk("ade_empty", IF_Valid, 32'd0);
    tick();
    chk("ade_valid", IF_Valid, 32'd1);
    chk("ade_pc",    IF_PC,    32'h8000_0002);
    chk("ade_instr", IF_Instr, 32'h0);
    chk("ade_flag",  IF_AdEL,  32'd1);
    chk("ade_req2",  inst_req, 32'd0);
    tick(); tick();
    chk("halt_req",   inst_req, 32'd0);
    chk("halt_valid", IF_Valid, 32'd1);
    ID_Wr = 1'b1;
    tick();
    chk("halt_pop_valid", IF_Valid, 32'd0);
    chk("halt_pop_req",   inst_req, 32'd0);
    tick();
    chk("halt_idle_req", inst_req, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    tick();
    redirect_valid = 1'b0;
    chk("resume_req",  inst_req,  32'd1);
    chk("resume_addr", inst_addr, 32'h8000_0000);
    tick(); tick();
    chk("resume_valid", IF_Valid,  32'd1);
    chk("resume_pc",    IF_PC,     32'h8000_0000);
    chk("resume_adel",  IF_AdEL,   32'd0);
    chk("resume_instr", IF_Instr,  32'h7FFF_FFFF);
    chk("resume_next",  inst_addr, 32'h8000_0004);

    // Address held stable while the memory refuses the request
    mem_ack = 1'b0;
    tick();
    chk("stall_req",   inst_req,  32'd1);
    chk("stall_addr",  inst_addr, 32'h8000_0004);
    chk("stall_valid", IF_Valid,  32'd0);
    tick();
    chk("stall_addr2", inst_addr, 32'h8000_0004);
    mem_ack = 1'b1;
    tick(); tick();
    chk("stall_hit_pc", IF_PC, 32'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
